sap_control_seq: RTL and testbench
==================================

# sap_control_seq

Parametrised, variable-length control sequencer for the 8-bit SAP datapath; it is the next generation of the six-T-state ring-counter control unit. It decodes the 4-bit instruction-register opcode into per-T-state control strobes and ends each instruction after its last useful T-state. It adds store, conditional and unconditional jumps, a latched halt state and a run/freeze input. It drives the PC, MAR, RAM, IR, A, B, ALU and output-register enables directly.

## Interface
- OPW, 4: opcode width; only the low 4 bits are decoded, and upper bits must be zero for a valid opcode.
- EN_SKIP, 1: 1 = variable-length instructions; 0 = legacy fixed 6 T-states per instruction.
- EN_JUMP, 1: 1 = JMP/JZ/JC implemented; 0 = opcodes 4–6 decode as NOP.
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-high.
- ireg  in  OPW  opcode from instruction register.
- zf, cf  in  1 each  ALU zero/carry flags, sampled combinationally in T4.
- run  in  1  1 = sequence; 0 = freeze the current T-state.
- cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo  out  1 each  existing datapath strobes, with unchanged meanings.
- we  out  1  RAM write enable.
- lp  out  1  load PC from bus.
- tstate  out  6  one-hot current T-state (bit0 = T1).
- halted  out  1  HLT executed.

## Operation
- State: one-hot T1..T6 plus a HALT flag.
- Strobes are decoded combinationally from state, ireg, zf and cf.
- Any strobe not listed below is 0.
- Fetch, all opcodes:
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Execute phase, per opcode (a "→T1" entry marks the last T-state):
  - LDA 0: T4 lm, ei; T5 ce, la →T1.
  - ADD 1: T4 lm, ei; T5 ce, lb; T6 la, eu →T1.
  - SUB 2: same as ADD, with su high in T4, T5 and T6.
  - STA 3: T4 lm, ei; T5 ea, we →T1.
  - JMP 4: T4 ei, lp →T1.
  - JZ 5: T4 ei, lp only if zf=1 →T1.
  - JC 6: T4 ei, lp only if cf=1 →T1.
  - OUT 14: T4 ea, lo →T1.
  - HLT 15: T4 all strobes 0; set halted.
  - All other opcodes (including nonzero upper bits): NOP; T4 all 0 →T1.
- EN_SKIP=0: no early return; unused T-states output all-zero strobes and T6 always advances to T1.
- HALT: all strobes 0, tstate = 0, halted = 1. Only clr exits HALT.
- run=0: tstate holds and all strobes are forced to 0. On run=1 the held T-state's strobes reappear.
- run=0 during T4 of HLT: halted is not set until a T4 edge with run=1.

## Timing
- Reset, with clr high at a rising edge:
  - next-state values: tstate = 000001, halted = 0.
  - outputs immediately after: ep = 1, lm = 1, every other strobe 0, we = 0, lp = 0.
- clr has priority over run, over HALT and over any mid-instruction state.
- Strobes are valid in the cycle of their T-state. Datapath registers load on the next rising edge.
- Instruction length with EN_SKIP=1:
  - JMP/JZ/JC/OUT/NOP: 4 cycles.
  - LDA/STA: 5 cycles.
  - ADD/SUB: 6 cycles.
- With EN_SKIP=0, every instruction takes 6 cycles.
- zf and cf are sampled in the T4 cycle only; flag changes in other T-states have no effect.
- HLT: halted rises on the edge ending T4 and the sequence stays frozen indefinitely.
- ireg is treated as stable from T4 onward. It is decoded only when tstate ≥ T4.

## Structure
- Package sap_ctrl_pkg holds:
  - opcode constants (OP_LDA … OP_HLT);
  - T-state one-hot localparams;
  - control-word bit indices for the 14 strobes.
- Sub-module sap_tstate_ring: 6-bit one-hot ring with synchronous clr, hold (run), early-return-to-T1 (last) and halt inputs. It carries the sequential logic.
- sap_control_seq itself holds:
  - the combinational opcode/T-state decoder, which builds a 14-bit control word;
  - the run gating;
  - the halted register.

## Test plan
- Reset: clr=1 for 2 cycles, then released.
  - Required: tstate=000001, ep=lm=1, other strobes 0, halted=0.
  - Required: T2 (cp=1) on the next cycle.
- LDA then ADD, with EN_SKIP=1:
  - LDA: T5 shows ce=la=1, and the next cycle is T1 (5 cycles total).
  - ADD: T6 shows la=eu=1, and returns to T1 after 6 cycles.
- JZ with zf=1, then JZ with zf=0:
  - Required: lp=ei=1 in T4 only in the zf=1 case.
  - Required: both instructions take 4 cycles.
- STA: T5 shows ea=we=1. With EN_JUMP=0, opcode 4 produces no lp and takes 4 cycles.
- HLT, followed by 20 idle cycles:
  - Required: halted=1, tstate=0, all strobes 0 throughout.
  - Then clr=1: returns to T1 and halted=0.
- run=0 for 3 cycles during T5 of SUB:
  - Required: strobes 0 and tstate frozen while run=0.
  - Required: on resume, ce, lb and su reappear, then T6.
- EN_SKIP=0 variant: every instruction takes 6 cycles.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP control sequencer: opcodes, T-state
// encodings, control-word bit positions and the opcode classifier.
package sap_ctrl_pkg;

  // Opcode values as seen in the low four bits of the instruction register
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JZ  = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // One-hot T-state encodings; all-zero means the sequence is halted
  localparam logic [5:0] T_NONE = 6'b000000;
  localparam logic [5:0] T1     = 6'b000001;
  localparam logic [5:0] T2     = 6'b000010;
  localparam logic [5:0] T3     = 6'b000100;
  localparam logic [5:0] T4     = 6'b001000;
  localparam logic [5:0] T5     = 6'b010000;
  localparam logic [5:0] T6     = 6'b100000;

  // Control-word bit positions
  localparam int CW_W  = 14;
  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_CE = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_SU = 8;
  localparam int CW_EU = 9;
  localparam int CW_LB = 10;
  localparam int CW_LO = 11;
  localparam int CW_WE = 12;
  localparam int CW_LP = 13;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Instruction classes after validity and feature filtering
  typedef enum logic [3:0] {
    I_LDA = 4'd0,
    I_ADD = 4'd1,
    I_SUB = 4'd2,
    I_STA = 4'd3,
    I_JMP = 4'd4,
    I_JZ  = 4'd5,
    I_JC  = 4'd6,
    I_OUT = 4'd7,
    I_HLT = 4'd8,
    I_NOP = 4'd9
  } instr_e;

  // Single-strobe control word
  function automatic ctrl_word_t cw_bit(input int idx);
    return ctrl_word_t'(1) << idx;
  endfunction

  // Map a raw opcode onto an instruction class; invalid or disabled
  // opcodes collapse to NOP
  function automatic instr_e decode_instr(input logic [3:0] op,
                                          input logic       valid,
                                          input logic       jumps);
    instr_e r;
    r = I_NOP;
    if (valid) begin
      case (op)
        OP_LDA:  r = I_LDA;
        OP_ADD:  r = I_ADD;
        OP_SUB:  r = I_SUB;
        OP_STA:  r = I_STA;
        OP_JMP:  r = jumps ? I_JMP : I_NOP;
        OP_JZ:   r = jumps ? I_JZ  : I_NOP;
        OP_JC:   r = jumps ? I_JC  : I_NOP;
        OP_OUT:  r = I_OUT;
        OP_HLT:  r = I_HLT;
        default: r = I_NOP;
      endcase
    end else begin
      r = I_NOP;
    end
    return r;
  endfunction

endpackage

// File: rtl/sap_control_seq_ring.sv
// Six-state one-hot T-state ring. Freezes while run is low, returns early
// to T1 on last, and parks at all-zero on halt until clr.
module sap_tstate_ring
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       last,
  input  logic       halt,
  output logic [5:0] tstate
);

  logic [5:0] ring_r;

  // Advance, hold, short-cut or park the ring; clr always wins
  always_ff @(posedge clk) begin
    if (clr) begin
      ring_r <= T1;
    end else if (!run) begin
      ring_r <= ring_r;
    end else if (halt) begin
      ring_r <= T_NONE;
    end else if (last) begin
      ring_r <= T1;
    end else begin
      // Rotation of the all-zero halted state stays all-zero
      ring_r <= {ring_r[4:0], ring_r[5]};
    end
  end

  assign tstate = ring_r;

endmodule

// File: rtl/sap_control_seq.sv
// Variable-length SAP control sequencer: decodes opcode and T-state into
// datapath strobes, gates them with run, and latches the halt condition.
module sap_control_seq
  import sap_ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int EN_SKIP = 1,
  parameter int EN_JUMP = 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [OPW-1:0] ireg,
  input  logic           zf,
  input  logic           cf,
  input  logic           run,
  output logic           cp,
  output logic           ep,
  output logic           lm,
  output logic           ce,
  output logic           li,
  output logic           ei,
  output logic           la,
  output logic           ea,
  output logic           su,
  output logic           eu,
  output logic           lb,
  output logic           lo,
  output logic           we,
  output logic           lp,
  output logic [5:0]     tstate,
  output logic           halted
);

  logic       op_valid;
  instr_e     instr;
  ctrl_word_t cw;
  ctrl_word_t cw_out;
  logic       last_hit;
  logic       halt_hit;
  logic       ring_last;
  logic       halt_set;
  logic       halted_r;
  logic [5:0] ring_state;

  // Any set bit above the 4-bit opcode field makes the opcode a NOP
  assign op_valid = ((ireg >> 4) == '0);
  assign instr    = decode_instr(ireg[3:0], op_valid, (EN_JUMP != 0));

  // Control-word decode from T-state, instruction class and flags
  always_comb begin
    cw       = '0;
    last_hit = 1'b0;
    halt_hit = 1'b0;
    case (ring_state)
      T1: cw = cw_bit(CW_EP) | cw_bit(CW_LM);
      T2: cw = cw_bit(CW_CP);
      T3: cw = cw_bit(CW_CE) | cw_bit(CW_LI);
      T4: begin
        case (instr)
          I_LDA, I_ADD, I_STA: cw = cw_bit(CW_LM) | cw_bit(CW_EI);
          I_SUB: cw = cw_bit(CW_LM) | cw_bit(CW_EI) | cw_bit(CW_SU);
          I_JMP: begin
            cw       = cw_bit(CW_EI) | cw_bit(CW_LP);
            last_hit = 1'b1;
          end
          I_JZ: begin
            if (zf) begin
              cw = cw_bit(CW_EI) | cw_bit(CW_LP);
            end else begin
              cw = '0;
            end
            last_hit = 1'b1;
          end
          I_JC: begin
            if (cf) begin
              cw = cw_bit(CW_EI) | cw_bit(CW_LP);
            end else begin
              cw = '0;
            end
            last_hit = 1'b1;
          end
          I_OUT: begin
            cw       = cw_bit(CW_EA) | cw_bit(CW_LO);
            last_hit = 1'b1;
          end
          I_HLT: halt_hit = 1'b1;
          default: last_hit = 1'b1;
        endcase
      end
      T5: begin
        case (instr)
          I_LDA: begin
            cw       = cw_bit(CW_CE) | cw_bit(CW_LA);
            last_hit = 1'b1;
          end
          I_ADD: cw = cw_bit(CW_CE) | cw_bit(CW_LB);
          I_SUB: cw = cw_bit(CW_CE) | cw_bit(CW_LB) | cw_bit(CW_SU);
          I_STA: begin
            cw       = cw_bit(CW_EA) | cw_bit(CW_WE);
            last_hit = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      T6: begin
        case (instr)
          I_ADD:   cw = cw_bit(CW_LA) | cw_bit(CW_EU);
          I_SUB:   cw = cw_bit(CW_LA) | cw_bit(CW_EU) | cw_bit(CW_SU);
          default: cw = '0;
        endcase
        last_hit = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  // Legacy mode never shortens an instruction; T6 wraps by rotation
  assign ring_last = last_hit && (EN_SKIP != 0);
  // A frozen T4 of HLT must not halt until run returns
  assign halt_set  = run && halt_hit;

  sap_tstate_ring u_ring (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .last   (ring_last),
    .halt   (halt_hit),
    .tstate (ring_state)
  );

  // Halt flag: set on the T4 edge of HLT, cleared only by clr
  always_ff @(posedge clk) begin
    if (clr) begin
      halted_r <= 1'b0;
    end else if (halt_set) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // Strobes are silenced while frozen or halted
  assign cw_out = (run && !halted_r) ? cw : '0;

  assign cp     = cw_out[CW_CP];
  assign ep     = cw_out[CW_EP];
  assign lm     = cw_out[CW_LM];
  assign ce     = cw_out[CW_CE];
  assign li     = cw_out[CW_LI];
  assign ei     = cw_out[CW_EI];
  assign la     = cw_out[CW_LA];
  assign ea     = cw_out[CW_EA];
  assign su     = cw_out[CW_SU];
  assign eu     = cw_out[CW_EU];
  assign lb     = cw_out[CW_LB];
  assign lo     = cw_out[CW_LO];
  assign we     = cw_out[CW_WE];
  assign lp     = cw_out[CW_LP];
  assign tstate = ring_state;
  assign halted = halted_r;

endmodule

// File: tb/tb_sap_control_seq.sv
// Scoreboard bench for sap_control_seq. Three instances cover
// variable-length with jumps, jumps disabled, and fixed 6-state mode.
module tb_sap_control_seq;

  // Bench-local strobe order: cp ep lm ce li ei la ea su eu lb lo we lp
  localparam logic [13:0] M_CP = 14'h0001;
  localparam logic [13:0] M_EP = 14'h0002;
  localparam logic [13:0] M_LM = 14'h0004;
  localparam logic [13:0] M_CE = 14'h0008;
  localparam logic [13:0] M_LI = 14'h0010;
  localparam logic [13:0] M_EI = 14'h0020;
  localparam logic [13:0] M_LA = 14'h0040;
  localparam logic [13:0] M_EA = 14'h0080;
  localparam logic [13:0] M_SU = 14'h0100;
  localparam logic [13:0] M_EU = 14'h0200;
  localparam logic [13:0] M_LB = 14'h0400;
  localparam logic [13:0] M_LO = 14'h0800;
  localparam logic [13:0] M_WE = 14'h1000;
  localparam logic [13:0] M_LP = 14'h2000;
  localparam logic [13:0] M_0  = 14'h0000;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  localparam int SKIP_P [3] = '{1, 1, 0};
  localparam int JUMP_P [3] = '{1, 0, 1};

  typedef struct {
    int          d;
    logic [5:0]  t;
    logic [13:0] cw;
    logic        h;
  } exp_t;

  logic        clk;
  logic [2:0]  clr_v;
  logic [2:0]  run_v;
  logic [2:0]  zf_v;
  logic [2:0]  cf_v;
  logic [4:0]  ireg_v   [3];
  logic [13:0] cw_o     [3];
  logic [5:0]  tstate_o [3];
  logic        halted_o [3];

  exp_t  sb_q [$];
  int    n_checks;
  int    n_fail;
  int    cyc_no;
  string cur_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [13:0] cw_w;
    logic [5:0]  ts_w;
    logic        h_w;
    sap_control_seq #(
      .OPW     (5),
      .EN_SKIP (SKIP_P[g]),
      .EN_JUMP (JUMP_P[g])
    ) u_dut (
      .clk    (clk),
      .clr    (clr_v[g]),
      .ireg   (ireg_v[g]),
      .zf     (zf_v[g]),
      .cf     (cf_v[g]),
      .run    (run_v[g]),
      .cp     (cw_w[0]),
      .ep     (cw_w[1]),
      .lm     (cw_w[2]),
      .ce     (cw_w[3]),
      .li     (cw_w[4]),
      .ei     (cw_w[5]),
      .la     (cw_w[6]),
      .ea     (cw_w[7]),
      .su     (cw_w[8]),
      .eu     (cw_w[9]),
      .lb     (cw_w[10]),
      .lo     (cw_w[11]),
      .we     (cw_w[12]),
      .lp     (cw_w[13]),
      .tstate (ts_w),
      .halted (h_w)
    );
    assign cw_o[g]     = cw_w;
    assign tstate_o[g] = ts_w;
    assign halted_o[g] = h_w;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cyc=%0d: got %0h expected %0h", cur_tag, tag, cyc_no, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the named instance
  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("tstate", 32'(tstate_o[e.d]), 32'(e.t));
      check_eq("strobes", 32'(cw_o[e.d]), 32'(e.cw));
      check_eq("halted", 32'(halted_o[e.d]), 32'(e.h));
    end
  endtask

  // One clock cycle: inputs already driven at negedge, push, observe, advance
  task automatic cyc(input int d, input logic [5:0] et, input logic [13:0] ec, input logic eh);
    exp_t e;
    e.d = d; e.t = et; e.cw = ec; e.h = eh;
    sb_q.push_back(e);
    #1;
    pop_check();
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    clr_v[d] = 1'b1;
    run_v[d] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_v[d] = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [4:0] op);
    ireg_v[d] = op;
    cyc(d, S1, M_EP | M_LM, 1'b0);
    cyc(d, S2, M_CP, 1'b0);
    cyc(d, S3, M_CE | M_LI, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc_no   = 0;
    clr_v    = 3'b111;
    run_v    = 3'b111;
    zf_v     = 3'b000;
    cf_v     = 3'b000;
    for (int i = 0; i < 3; i++) ireg_v[i] = 5'd0;
    @(negedge clk);

    // ---------------- instance 0: variable length, jumps on ----------------
    cur_tag = "reset";
    do_reset(0);
    cyc(0, S1, M_EP | M_LM, 1'b0);
    cyc(0, S2, M_CP, 1'b0);
    cyc(0, S3, M_CE | M_LI, 1'b0);
    cyc(0, S4, M_LM | M_EI, 1'b0);          // ireg=0 -> LDA
    cyc(0, S5, M_CE | M_LA, 1'b0);

    cur_tag = "add";
    fetch(0, 5'd1);
    cyc(0, S4, M_LM | M_EI, 1'b0);
    cyc(0, S5, M_CE | M_LB, 1'b0);
    cyc(0, S6, M_LA | M_EU, 1'b0);

    cur_tag = "jz1";
    fetch(0, 5'd5);
    zf_v[0] = 1'b1;
    cyc(0, S4, M_EI | M_LP, 1'b0);

    cur_tag = "jz0";
    zf_v[0] = 1'b1;                          // set during fetch, cleared in T4
    fetch(0, 5'd5);
    zf_v[0] = 1'b0;
    cyc(0, S4, M_0, 1'b0);

    cur_tag = "sta";
    zf_v[0] = 1'b1;
    fetch(0, 5'd3);
    cyc(0, S4, M_LM | M_EI, 1'b0);
    cyc(0, S5, M_EA | M_WE, 1'b0);

    cur_tag = "jc";
    fetch(0, 5'd6);
    cf_v[0] = 1'b1;
    cyc(0, S4, M_EI | M_LP, 1'b0);
    fetch(0, 5'd6);
    cf_v[0] = 1'b0;
    cyc(0, S4, M_0, 1'b0);

    cur_tag = "jmp_out_nop";
    fetch(0, 5'd4);
    cyc(0, S4, M_EI | M_LP, 1'b0);
    fetch(0, 5'd14);
    cyc(0, S4, M_EA | M_LO, 1'b0);
    fetch(0, 5'd9);
    cyc(0, S4, M_0, 1'b0);
    fetch(0, 5'b10001);                       // upper bit set -> NOP
    cyc(0, S4, M_0, 1'b0);
    fetch(0, 5'b11111);                       // not HLT
    cyc(0, S4, M_0, 1'b0);

    cur_tag = "sub_freeze";
    fetch(0, 5'd2);
    cyc(0, S4, M_LM | M_EI | M_SU, 1'b0);
    run_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, S5, M_0, 1'b0);
    run_v[0] = 1'b1;
    cyc(0, S5, M_CE | M_LB | M_SU, 1'b0);
    cyc(0, S6, M_LA | M_EU | M_SU, 1'b0);

    cur_tag = "hlt";
    fetch(0, 5'd15);
    run_v[0] = 1'b0;
    cyc(0, S4, M_0, 1'b0);
    cyc(0, S4, M_0, 1'b0);
    run_v[0] = 1'b1;
    cyc(0, S4, M_0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_v[0] = (i % 5 != 3);
      cyc(0, S0, M_0, 1'b1);
    end
    run_v[0] = 1'b1;
    clr_v[0] = 1'b1;
    cyc(0, S0, M_0, 1'b1);
    clr_v[0] = 1'b0;

    cur_tag = "clr_mid";
    fetch(0, 5'd1);
    cyc(0, S4, M_LM | M_EI, 1'b0);
    clr_v[0] = 1'b1;
    cyc(0, S5, M_CE | M_LB, 1'b0);
    clr_v[0] = 1'b0;
    cyc(0, S1, M_EP | M_LM, 1'b0);
    clr_v[0] = 1'b1;

    // ---------------- instance 1: jumps disabled ----------------
    cur_tag = "nojump";
    do_reset(1);
    ireg_v[1] = 5'd4;
    cyc(1, S1, M_EP | M_LM, 1'b0);
    cyc(1, S2, M_CP, 1'b0);
    cyc(1, S3, M_CE | M_LI, 1'b0);
    cyc(1, S4, M_0, 1'b0);
    zf_v[1] = 1'b1;
    fetch(1, 5'd5);
    cyc(1, S4, M_0, 1'b0);
    fetch(1, 5'd3);
    cyc(1, S4, M_LM | M_EI, 1'b0);
    cyc(1, S5, M_EA | M_WE, 1'b0);
    cyc(1, S1, M_EP | M_LM, 1'b0);
    clr_v[1] = 1'b1;

    // ---------------- instance 2: fixed six T-states ----------------
    cur_tag = "fixed";
    do_reset(2);
    fetch(2, 5'd0);
    cyc(2, S4, M_LM | M_EI, 1'b0);
    cyc(2, S5, M_CE | M_LA, 1'b0);
    cyc(2, S6, M_0, 1'b0);
    fetch(2, 5'd4);
    cyc(2, S4, M_EI | M_LP, 1'b0);
    cyc(2, S5, M_0, 1'b0);
    cyc(2, S6, M_0, 1'b0);
    fetch(2, 5'd2);
    cyc(2, S4, M_LM | M_EI | M_SU, 1'b0);
    cyc(2, S5, M_CE | M_LB | M_SU, 1'b0);
    cyc(2, S6, M_LA | M_EU | M_SU, 1'b0);
    fetch(2, 5'd14);
    cyc(2, S4, M_EA | M_LO, 1'b0);
    cyc(2, S5, M_0, 1'b0);
    cyc(2, S6, M_0, 1'b0);
    cyc(2, S1, M_EP | M_LM, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
